// File: rtl/alu_pkg.sv
// Shared op codes, FSM state and flag bundle for the multicycle ALU.
// Both the top and the multiplier datapath import this package.
package alu_pkg;

    localparam logic [3:0] OP_DEF  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_CMP  = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_SLLV = 4'b1110;
    localparam logic [3:0] OP_SRLV = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic negative;
    } flags_t;

endpackage

// File: rtl/alu_shift_mul.sv
// Iterative shift-add multiplier datapath: one partial product per step.
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_shift_mul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product
);
    import alu_pkg::*;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;

    // product already includes the current step, so the final step can be
    // captured by the top on the same edge that ends the operation
    assign last    = (count == '0);
    assign product = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
        end
    end

endmodule
`endif

// File: rtl/multicycle_alu.sv
// Registered ALU with start/busy/done handshake; single-cycle ops finish in one
// cycle, MUL is iterative and exists only when ALU_MUL_EN is defined.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         ctrl,
    input  logic [WIDTH-1:0]   bus_a,
    input  logic [WIDTH-1:0]   bus_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               negative,
    output logic               busy,
    output logic               done
);
    import alu_pkg::*;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_eq_b;
    logic             a_lt_b;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;
    flags_t           flags_q;

    assign sum    = bus_a + bus_b;
    assign diff   = bus_a - bus_b;
    assign a_eq_b = (bus_a == bus_b);
    assign a_lt_b = ($signed(bus_a) < $signed(bus_b));

    // CMP and BEQ report the comparison in the flags rather than the result
    always_comb begin
        alu_res            = '0;
        alu_flags.overflow = 1'b0;
        case (ctrl)
            OP_AND:  alu_res = bus_a & bus_b;
            OP_ADD: begin
                alu_res            = sum;
                alu_flags.overflow = (bus_a[WIDTH-1] == bus_b[WIDTH-1]) &&
                                     (sum[WIDTH-1] != bus_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res            = diff;
                alu_flags.overflow = (bus_a[WIDTH-1] != bus_b[WIDTH-1]) &&
                                     (diff[WIDTH-1] != bus_a[WIDTH-1]);
            end
            OP_CMP:  alu_res = {{(WIDTH-1){1'b0}}, a_lt_b};
            OP_SRA:  alu_res = $unsigned($signed(bus_a) >>> shamt);
            OP_SLL:  alu_res = bus_a << shamt;
            OP_SRL:  alu_res = bus_a >> shamt;
            OP_SLLV: alu_res = bus_a << bus_b[SHAMT_W-1:0];
            OP_SRLV: alu_res = bus_a >> bus_b[SHAMT_W-1:0];
            default: alu_res = '0;
        endcase
        alu_flags.zero     = (ctrl == OP_CMP || ctrl == OP_BEQ) ? a_eq_b : (alu_res == '0);
        alu_flags.negative = (ctrl == OP_CMP) ? a_lt_b : alu_res[WIDTH-1];
    end

    assign zero     = flags_q.zero;
    assign overflow = flags_q.overflow;
    assign negative = flags_q.negative;

`ifdef ALU_MUL_EN
    state_t           state;
    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic [WIDTH-1:0] mul_prod;

    assign mul_load = (state == IDLE) && start && (ctrl == OP_MUL);
    assign mul_step = (state == MUL);

    alu_shift_mul #(.WIDTH(WIDTH)) u_shift_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .step    (mul_step),
        .a       (bus_a),
        .b       (bus_b),
        .last    (mul_last),
        .product (mul_prod)
    );

    // start is only looked at in IDLE, so re-pulses during MUL are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            flags_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ctrl == OP_MUL) begin
                            state <= MUL;
                            busy  <= 1'b1;
                        end else begin
                            result  <= alu_res;
                            flags_q <= alu_flags;
                            done    <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        result           <= mul_prod;
                        flags_q.zero     <= (mul_prod == '0);
                        flags_q.overflow <= 1'b0;
                        flags_q.negative <= mul_prod[WIDTH-1];
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            flags_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                result  <= alu_res;
                flags_q <= alu_flags;
                done    <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu; MUL steps are built only
// when ALU_MUL_EN is defined, otherwise code 0110 is checked as the default op.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [3:0]         ctrl;
    logic [WIDTH-1:0]   bus_a;
    logic [WIDTH-1:0]   bus_b;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               overflow;
    logic               negative;
    logic               busy;
    logic               done;

    int n_checks;
    int n_fail;
    int cyc;
    logic done_seen;
    logic busy_dropped;

    multicycle_alu #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ctrl     (ctrl),
        .bus_a    (bus_a),
        .bus_b    (bus_b),
        .shamt    (shamt),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .negative (negative),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one full cycle, leaving us just after the rising edge
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // drive one start pulse; returns just after the accepting edge
    task automatic issue(input logic [3:0] c, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [SHAMT_W-1:0] sh);
        @(negedge clk);
        ctrl  = c;
        bus_a = a;
        bus_b = b;
        shamt = sh;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // wait (bounded) for done, counting cycles in cyc
    task automatic wait_done(input int limit);
        while (!done && cyc < limit) begin
            if (!busy) busy_dropped = 1'b1;
            step();
            cyc++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        start    = 1'b0;
        ctrl     = OP_DEF;
        bus_a    = '0;
        bus_b    = '0;
        shamt    = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_overflow", overflow, 0);
        check("rst_negative", negative, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle operand changes without start do nothing
        bus_a = 32'h1234_5678;
        bus_b = 32'h1234_5678;
        ctrl  = OP_ADD;
        step();
        step();
        check("idle_done", done, 0);
        check("idle_result", result, 0);

        issue(OP_ADD, 32'h8000_0000, 32'h8000_0000, 0);
        check("add_ovf_done", done, 1);
        check("add_ovf_result", result, 0);
        check("add_ovf_zero", zero, 1);
        check("add_ovf_overflow", overflow, 1);
        check("add_ovf_negative", negative, 0);
        check("add_ovf_busy", busy, 0);
        step();
        check("add_done_pulse", done, 0);
        check("add_result_held", result, 0);

        issue(OP_SUB, 3, 7, 0);
        check("sub_result", result, 32'hFFFF_FFFC);
        check("sub_negative", negative, 1);
        check("sub_overflow", overflow, 0);
        check("sub_zero", zero, 0);

        issue(OP_CMP, 3, 7, 0);
        check("cmp_result", result, 1);
        check("cmp_negative", negative, 1);
        check("cmp_zero", zero, 0);

        issue(OP_SUB, 32'h8000_0000, 1, 0);
        check("sub_ovf_result", result, 32'h7FFF_FFFF);
        check("sub_ovf_overflow", overflow, 1);

        issue(OP_SLL, 32'h1111_1111, 0, 1);
        check("sll_result", result, 32'h2222_2222);
        issue(OP_SRLV, 32'h1111_1111, 1, 0);
        check("srlv_result", result, 32'h0888_8888);
        issue(OP_SRA, 32'h8000_0000, 0, 4);
        check("sra_result", result, 32'hF800_0000);
        check("sra_negative", negative, 1);
        issue(OP_SRL, 32'h8000_0000, 0, 4);
        check("srl_result", result, 32'h0800_0000);
        issue(OP_SLLV, 1, 32'h0000_0021, 0);
        check("sllv_mask_result", result, 2);

        issue(OP_DEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("def_result", result, 0);
        check("def_zero", zero, 1);

`ifdef ALU_MUL_EN
        issue(OP_MUL, 123, 456, 0);
        cyc          = 0;
        busy_dropped = 1'b0;
        done_seen    = 1'b0;
        check("mul_busy_accept", busy, 1);
        check("mul_done_accept", done, 0);
        bus_a = 32'hDEAD_BEEF;
        bus_b = 32'h0;
        for (int i = 0; i < 9; i++) begin
            step();
            cyc++;
            if (!busy) busy_dropped = 1'b1;
            if (done) done_seen = 1'b1;
        end
        @(negedge clk);
        ctrl  = OP_ADD;
        bus_a = 1;
        bus_b = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        wait_done(40);
        check("mul_latency", cyc, WIDTH);
        check("mul_no_early_done", done_seen, 0);
        check("mul_busy_held", busy_dropped, 0);
        check("mul_result", result, 56088);
        check("mul_busy_end", busy, 0);
        check("mul_overflow", overflow, 0);
        step();
        check("mul_restart_ignored", done, 0);
        check("mul_result_held", result, 56088);

        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0);
        cyc = 0;
        wait_done(40);
        check("mul_wrap_result", result, 0);
        check("mul_wrap_zero", zero, 1);

        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        cyc = 0;
        wait_done(40);
        check("mul_ff_latency", cyc, WIDTH);
        check("mul_ff_result", result, 1);
        check("mul_ff_negative", negative, 0);

        issue(OP_MUL, 5, 6, 0);
        for (int i = 0; i < 9; i++) step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mulrst_result", result, 0);
        check("mulrst_busy", busy, 0);
        check("mulrst_done", done, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) done_seen = 1'b1;
        end
        check("mulrst_no_done", done_seen, 0);
`else
        issue(OP_MUL, 123, 456, 0);
        check("mul_off_done", done, 1);
        check("mul_off_result", result, 0);
        check("mul_off_zero", zero, 1);
        check("mul_off_busy", busy, 0);
`endif

        issue(OP_BEQ, 7, 7, 0);
        check("beq_eq_done", done, 1);
        check("beq_eq_zero", zero, 1);
        check("beq_eq_result", result, 0);
        issue(OP_BEQ, 7, 8, 0);
        check("beq_ne_zero", zero, 0);

        issue(OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 0);
        check("b2b_and_done", done, 1);
        check("b2b_and_result", result, 0);
        check("b2b_and_zero", zero, 1);
        issue(OP_ADD, 1, 1, 0);
        check("b2b_add_done", done, 1);
        check("b2b_add_result", result, 2);
        check("b2b_add_zero", zero, 0);
        step();
        check("b2b_done_drop", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered successor to the combinational processor ALU.
- Keeps the existing 4-bit ALU control encoding and flag set.
- Adds a width parameter, a start/busy/done handshake, an iterative shift-add multiplier, and an arithmetic right shift.
- Sits in the EX stage of the multicycle datapath; the control FSM holds in EX while busy is high.

Parameters:
WIDTH, 32, datapath width in bits (power of two, 8..64)
SHAMT_W, $clog2(WIDTH), width of shift amount

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
ctrl  input  4  ALU control code (see Behaviour)
bus_a  input  WIDTH  operand A
bus_b  input  WIDTH  operand B
shamt  input  SHAMT_W  immediate shift amount
result  output  WIDTH  registered result, held until next completion
zero  output  1  registered: result==0 (BEQ: A==B)
overflow  output  1  registered signed overflow (ADD/SUB only, else 0)
negative  output  1  registered: result[WIDTH-1] (CMP: A<B signed)
busy  output  1  high while a multi-cycle op is in progress
done  output  1  one-cycle pulse when result/flags update

Behaviour:
- Reset (async assert, sync-release assumed upstream): result=0, zero=0, overflow=0, negative=0, busy=0, done=0, FSM=IDLE. Reset mid-multiply aborts with no done pulse.
- Ctrl codes:
  - 0001 AND.
  - 0010 ADD.
  - 0011 SUB (A-B).
  - 0100 CMP: result=1 if A<B signed else 0; zero=(A==B); negative=(A<B).
  - 0101 BEQ: result=0; zero=(A==B).
  - 0110 MUL: low WIDTH bits of A*B, unsigned.
  - 0111 SRA: A>>>shamt.
  - 1100 SLL: A<<shamt.
  - 1101 SRL: A>>shamt.
  - 1110 SLLV: A<<B[SHAMT_W-1:0].
  - 1111 SRLV: A>>B[SHAMT_W-1:0].
  - 0000 and unused codes: result=0, flags zero=1, others 0.
- Overflow: ADD = A,B same sign and sum sign differs. SUB = A,B signs differ and diff sign differs from A. Result wraps modulo 2^WIDTH.
- FSM states: IDLE, MUL.
  - IDLE, start=1, ctrl!=MUL: compute combinationally, register result/flags at the same edge, done=1 the following cycle. Latency 1, busy stays 0.
  - IDLE, start=1, ctrl=MUL: capture A, B, clear accumulator, load counter=WIDTH-1, go to MUL, busy=1 next cycle.
  - MUL: each cycle, if multiplier LSB then acc+=multiplicand; multiplicand<<=1, multiplier>>=1.
  - MUL exit: at count 0, register result/flags (overflow=0), busy=0, done=1, return to IDLE.
  - MUL latency: done visible exactly WIDTH cycles after the accepting edge.
- start with busy=1 is ignored; no queueing. Operands may change after acceptance.
- start on the same cycle done=1 is accepted normally; back-to-back single-cycle ops give done every cycle.
- Operand or ctrl changes while idle without start have no effect on outputs.

Optional Feature:
ALU_MUL_EN
- Defined: MUL state, counter, accumulator and code 0110 are built as above.
- Undefined: no MUL state. Code 0110 behaves as the default code (result=0, zero=1, latency 1). busy is tied 0.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit op code localparams: OP_DEF, OP_AND, OP_ADD, OP_SUB, OP_CMP, OP_BEQ, OP_MUL, OP_SRA, OP_SLL, OP_SRL, OP_SLLV, OP_SRLV;
  - the FSM state enum;
  - a flag struct {zero, overflow, negative}.
- Single sub-module alu_shift_mul: iterative multiplier datapath (accumulator, shift registers, counter) with load/step/last signals. Compiled only under ALU_MUL_EN.

Test Plan:
- ADD, A=32'h8000_0000, B=32'h8000_0000, start pulse -> 1 cycle later done=1, result=0, zero=1, overflow=1, negative=0.
- SUB, A=3, B=7 -> result=32'hFFFF_FFFC, negative=1, overflow=0; then CMP same operands -> result=1, negative=1, zero=0.
- Shifts, A=32'h1111_1111:
  - SLL shamt=1 -> 32'h2222_2222;
  - SRLV B=1 -> 32'h0888_8888;
  - SRA A=32'h8000_0000, shamt=4 -> 32'hF800_0000.
- MUL (ALU_MUL_EN), A=123, B=456 -> busy=1 for 32 cycles, done exactly 32 cycles after accept, result=56088.
  - start re-pulsed mid-op is ignored.
  - A=B=32'hFFFF_FFFF -> result=1.
- rst_n pulsed low in the 10th cycle of MUL -> outputs 0 immediately, no done pulse. BEQ A=B=7 then gives zero=1 in 1 cycle.
- Back-to-back: AND then ADD on consecutive cycles -> done high 2 consecutive cycles with correct results.
  - AND: A=32'hAAAA_AAAA, B=32'h5555_5555 -> 0, zero=1.
  - ADD: A=B=1 -> 2.
